cache_mem_arbiter: RTL and testbench
====================================

# cache_mem_arbiter

Two-port burst-read arbiter that shares the single instruction/data memory read port between the instruction cache and the data cache. Each cache issues line-fill requests using the same read/full/ready/data protocol the memory presents; the arbiter grants one requester at a time, forwards the line-aligned address, and steers the returned burst to the owner. Priority alternates after every completed burst, so neither cache can starve the other.

## Interface
- ADDR_WIDTH, 16, word-address width of all address ports.
- DATA_WIDTH, 32, width of all data ports.
- BURST_LOG2, 4, log2 of words per line fill; one burst is 2^BURST_LOG2 `ready_i` beats.

- clock_i  in  1  system clock; all state changes on its rising edge.
- reset_ni  in  1  reset, asynchronous assert, active-low.
- i_read_i  in  1  icache request; held high until accepted.
- i_addr_i  in  ADDR_WIDTH  icache request address.
- i_full_o  out  1  icache backpressure; request accepted on a cycle with `i_read_i`=1 and `i_full_o`=0.
- i_ready_o  out  1  icache data beat valid.
- i_data_o  out  DATA_WIDTH  icache data (equals `data_i`).
- d_read_i, d_addr_i, d_full_o, d_ready_o, d_data_o: dcache port, identical to the icache port.
- read_o  out  1  memory read request (registered).
- full_i  in  1  memory backpressure; `read_o` accepted when `full_i`=0.
- ready_i  in  1  memory data beat valid.
- addr_o  out  ADDR_WIDTH  memory line address, low BURST_LOG2 bits zero (registered).
- data_i  in  DATA_WIDTH  memory read data.
- busy_o  out  1  high whenever state is not IDLE.
- grant_o  out  1  current/last owner: 0 = icache, 1 = dcache.

## Operation
- States: IDLE, ISSUE, BURST. Registers: state, grant, prio (next preferred requester), addr_o, read_o, beat counter (BURST_LOG2 bits).
- IDLE: accept one request. One requester active: it wins. Both active: `prio` wins. On acceptance: grant←winner, addr_o←winner address with low BURST_LOG2 bits cleared, read_o←1, counter←0, state→ISSUE.
- ISSUE: hold read_o and addr_o stable while `full_i`=1. When `full_i`=0: read_o←0, state→BURST.
- BURST: each `ready_i`=1 cycle is one beat: counter++ and owner's ready output asserted. Final beat (counter = 2^BURST_LOG2−1): state→IDLE, prio←other requester, counter wraps to 0.
- `ready_i` outside BURST is ignored: not counted, not forwarded.
- Full outputs (combinational): x_full_o = (state≠IDLE) | (other requester also requesting in IDLE and prio = other).
- Ready outputs (combinational): x_ready_o = ready_i & (state=BURST) & (grant=x). Both data outputs are wired to `data_i`.
- Reset (any time, including mid-burst): state IDLE, read_o 0, addr_o 0, grant 0, prio icache, counter 0, busy_o 0. Ready outputs 0 immediately. Full outputs follow the IDLE equation. Beats of an interrupted burst are dropped. The memory side is reset by the same signal.

## Timing
- Request accepted at edge N → read_o=1 and addr_o valid from N+1. With `full_i`=0 at N+1, read_o=0 from N+2 and BURST is entered at N+2.
- A beat at cycle k is presented on x_ready_o/x_data_o in cycle k (zero latency).
- Last beat at cycle k → IDLE at k+1 → a new request may be accepted at edge k+1 → read_o=1 at k+2. Minimum gap between bursts is 2 cycles.
- A request held during ISSUE/BURST sees full_o=1 and is accepted in the first IDLE cycle.

## Test plan
- Single icache fetch, i_addr_i=0x0014, full_i=0, memory returns 16 beats → read_o high exactly 1 cycle, addr_o=0x0010, 16 i_ready_o pulses with matching data, d_ready_o never high, then busy_o=0 and prio=dcache.
- Both requests asserted in the first cycle after reset, held → icache served first (addr_o of icache), dcache second. Third simultaneous pair → icache served again (strict alternation).
- full_i held high for 3 cycles after issue → read_o high 4 cycles, addr_o stable, no beats counted until BURST.
- dcache requests at beat 5 of an icache burst → d_full_o=1 through the final beat, accepted on the IDLE cycle, read_o high 2 cycles after the icache final beat.
- reset_ni pulled low at beat 7 → read_o, ready outputs, busy_o drop asynchronously. After release, a fresh icache request completes a full 16-beat burst.
- ready_i pulsed in IDLE and ISSUE → no x_ready_o, counter unchanged, the following burst still takes exactly 16 beats.

Source files
------------

// File: rtl/cache_mem_arbiter.sv
// Shares one burst-read memory port between the icache and dcache.
// Ownership is granted per line fill, and priority alternates after each completed burst.
module cache_mem_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int BURST_LOG2 = 4
) (
    input  logic                  clock_i,
    input  logic                  reset_ni,
    input  logic                  i_read_i,
    input  logic [ADDR_WIDTH-1:0] i_addr_i,
    output logic                  i_full_o,
    output logic                  i_ready_o,
    output logic [DATA_WIDTH-1:0] i_data_o,
    input  logic                  d_read_i,
    input  logic [ADDR_WIDTH-1:0] d_addr_i,
    output logic                  d_full_o,
    output logic                  d_ready_o,
    output logic [DATA_WIDTH-1:0] d_data_o,
    output logic                  read_o,
    input  logic                  full_i,
    input  logic                  ready_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  busy_o,
    output logic                  grant_o,
    output logic [1:0]            state_o
);

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, BURST = 2'd2} state_t;

    localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
        {{(ADDR_WIDTH-BURST_LOG2){1'b1}}, {BURST_LOG2{1'b0}}};

    state_t                state_q, state_d;
    logic                  grant_q, grant_d;
    logic                  prio_q, prio_d;
    logic                  read_q, read_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [BURST_LOG2-1:0] cnt_q, cnt_d;
    logic                  winner;

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            prio_q  <= 1'b0;
            read_q  <= 1'b0;
            addr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            prio_q  <= prio_d;
            read_q  <= read_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
        end
    end

    // A lone requester wins outright; prio only breaks ties.
    assign winner = (i_read_i && d_read_i) ? prio_q : d_read_i;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        prio_d  = prio_q;
        read_d  = read_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (i_read_i || d_read_i) begin
                    grant_d = winner;
                    addr_d  = (winner ? d_addr_i : i_addr_i) & LINE_MASK;
                    read_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (!full_i) begin
                    read_d  = 1'b0;
                    state_d = BURST;
                end
            end
            BURST: begin
                if (ready_i) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == '1) begin
                        state_d = IDLE;
                        prio_d  = ~grant_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o    = (state_q != IDLE);
    assign grant_o   = grant_q;
    assign state_o   = state_q;
    assign read_o    = read_q;
    assign addr_o    = addr_q;
    assign i_full_o  = busy_o | (d_read_i & prio_q);
    assign d_full_o  = busy_o | (i_read_i & ~prio_q);
    assign i_ready_o = ready_i & (state_q == BURST) & ~grant_q;
    assign d_ready_o = ready_i & (state_q == BURST) & grant_q;
    assign i_data_o  = data_i;
    assign d_data_o  = data_i;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: grants, alternation, backpressure, stray beats and reset.
module tb_cache_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_read = 1'b0, d_read = 1'b0;
    logic [15:0] i_addr = '0, d_addr = '0;
    logic        i_full, d_full, i_ready, d_ready;
    logic [31:0] i_data, d_data;
    logic        read_o, full = 1'b0, ready = 1'b0;
    logic [15:0] addr_o;
    logic [31:0] data = '0;
    logic        busy, grant;
    logic [1:0]  state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cache_mem_arbiter dut (
        .clock_i(clk), .reset_ni(rst_n),
        .i_read_i(i_read), .i_addr_i(i_addr), .i_full_o(i_full),
        .i_ready_o(i_ready), .i_data_o(i_data),
        .d_read_i(d_read), .d_addr_i(d_addr), .d_full_o(d_full),
        .d_ready_o(d_ready), .d_data_o(d_data),
        .read_o(read_o), .full_i(full), .ready_i(ready), .addr_o(addr_o),
        .data_i(data), .busy_o(busy), .grant_o(grant), .state_o(state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives 16 beats and checks each lands only on the owner's port.
    task automatic run_beats(input logic owner);
        for (int b = 0; b < 16; b++) begin
            ready = 1'b1;
            data  = $urandom;
            #1;
            chk("beat_own_ready", owner ? d_ready : i_ready, 1'b1);
            chk("beat_other_ready", owner ? i_ready : d_ready, 1'b0);
            chk("beat_data", owner ? d_data : i_data, data);
            chk("beat_busy", busy, 1'b1);
            tick();
        end
        ready = 1'b0;
        #1;
        chk("burst_done_busy", busy, 1'b0);
        chk("burst_done_state", state, 2'd0);
    endtask

    initial begin
        // reset
        tick(); tick();
        rst_n = 1'b1;
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_read", read_o, 1'b0);
        chk("rst_addr", addr_o, 16'h0000);
        chk("rst_grant", grant, 1'b0);
        chk("rst_i_full", i_full, 1'b0);
        chk("rst_d_full", d_full, 1'b0);

        // single icache fetch
        i_read = 1'b1; i_addr = 16'h0014;
        #1;
        chk("t1_i_full_idle", i_full, 1'b0);
        tick();
        chk("t1_read_issue", read_o, 1'b1);
        chk("t1_addr", addr_o, 16'h0010);
        chk("t1_grant", grant, 1'b0);
        chk("t1_i_full_busy", i_full, 1'b1);
        i_read = 1'b0;
        tick();
        chk("t1_read_one_cycle", read_o, 1'b0);
        chk("t1_state_burst", state, 2'd2);
        run_beats(1'b0);
        i_read = 1'b1; d_read = 1'b1;
        #1;
        chk("t1_prio_i_full", i_full, 1'b1);
        chk("t1_prio_d_full", d_full, 1'b0);
        i_read = 1'b0; d_read = 1'b0;

        // simultaneous requests after reset: icache, dcache, icache
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        i_read = 1'b1; i_addr = 16'h1234;
        d_read = 1'b1; d_addr = 16'hABCD;
        #1;
        chk("t2_i_full", i_full, 1'b0);
        chk("t2_d_full", d_full, 1'b1);
        tick();
        chk("t2_grant_i", grant, 1'b0);
        chk("t2_addr_i", addr_o, 16'h1230);
        i_read = 1'b0;
        tick();
        run_beats(1'b0);
        chk("t2_d_full_idle", d_full, 1'b0);
        tick();
        chk("t2_grant_d", grant, 1'b1);
        chk("t2_addr_d", addr_o, 16'hABC0);
        chk("t2_read_d", read_o, 1'b1);
        d_read = 1'b0;
        tick();
        run_beats(1'b1);
        i_read = 1'b1; d_read = 1'b1;
        #1;
        chk("t2_third_d_full", d_full, 1'b1);
        tick();
        chk("t2_third_grant", grant, 1'b0);
        chk("t2_third_addr", addr_o, 16'h1230);
        i_read = 1'b0; d_read = 1'b0;
        tick();
        run_beats(1'b0);

        // backpressure for 3 cycles with stray beats in ISSUE
        i_read = 1'b1; i_addr = 16'h0F0F; full = 1'b1;
        tick();
        i_read = 1'b0;
        for (int c = 0; c < 3; c++) begin
            ready = 1'b1;
            #1;
            chk("t3_read_held", read_o, 1'b1);
            chk("t3_addr_held", addr_o, 16'h0F00);
            chk("t3_no_ready", i_ready, 1'b0);
            tick();
        end
        chk("t3_read_4th", read_o, 1'b1);
        full = 1'b0; ready = 1'b0;
        tick();
        chk("t3_read_low", read_o, 1'b0);
        chk("t3_state_burst", state, 2'd2);
        run_beats(1'b0);
        ready = 1'b1;
        #1;
        chk("t6_idle_i_ready", i_ready, 1'b0);
        chk("t6_idle_d_ready", d_ready, 1'b0);
        tick();
        ready = 1'b0;

        // dcache request arriving at beat 5 of an icache burst
        i_read = 1'b1; i_addr = 16'h2000;
        tick();
        i_read = 1'b0;
        tick();
        for (int b = 0; b < 16; b++) begin
            if (b == 5) begin
                d_read = 1'b1; d_addr = 16'h3333;
            end
            ready = 1'b1;
            data  = $urandom;
            #1;
            chk("t4_i_ready", i_ready, 1'b1);
            chk("t4_d_ready", d_ready, 1'b0);
            if (b >= 5) chk("t4_d_full", d_full, 1'b1);
            tick();
        end
        ready = 1'b0;
        #1;
        chk("t4_idle_d_full", d_full, 1'b0);
        chk("t4_idle_read", read_o, 1'b0);
        tick();
        chk("t4_read_k2", read_o, 1'b1);
        chk("t4_grant", grant, 1'b1);
        chk("t4_addr", addr_o, 16'h3330);
        d_read = 1'b0;
        tick();
        run_beats(1'b1);

        // asynchronous reset at beat 7
        i_read = 1'b1; i_addr = 16'h4444;
        tick();
        i_read = 1'b0;
        tick();
        for (int b = 0; b < 7; b++) begin
            ready = 1'b1;
            #1;
            chk("t5_pre_ready", i_ready, 1'b1);
            tick();
        end
        ready = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_ready", i_ready, 1'b0);
        chk("t5_rst_busy", busy, 1'b0);
        chk("t5_rst_read", read_o, 1'b0);
        chk("t5_rst_addr", addr_o, 16'h0000);
        chk("t5_rst_i_full", i_full, 1'b0);
        ready = 1'b0;
        tick();
        rst_n = 1'b1;
        i_read = 1'b1; i_addr = 16'h5555;
        tick();
        chk("t5_new_addr", addr_o, 16'h5550);
        chk("t5_new_read", read_o, 1'b1);
        i_read = 1'b0;
        tick();
        run_beats(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
